// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like data interface: size encodings, response queue entry
// layout and the byte write-mask helpers.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
    logic [3:0]  age;
  } resp_entry_t;

  // Byte-lane write mask; reserved size 11 behaves as a full word.
  function automatic logic [3:0] wr_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] mask_expand(input logic [3:0] m);
    logic [31:0] e;
    for (int b = 0; b < 4; b++) begin
      e[b*8 +: 8] = {8{m[b]}};
    end
    return e;
  endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// In-order response FIFO. Each entry carries its own countdown; the head pops once it reaches 0.
module sram_like_resp_queue
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  resp_entry_t       i_push_entry,
  output logic              o_pop,
  output logic              o_head_is_read,
  output logic [31:0]       o_head_data,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  resp_entry_t      w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_head         = r_mem[r_head];
  assign o_pop          = (r_count != '0) && (w_head.age == 4'd0);
  assign o_head_is_read = w_head.is_read;
  assign o_head_data    = w_head.data;
  assign o_count        = r_count;

  // Stale slots also age down; harmless since count decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].age != 4'd0) begin
        r_mem[i].age <= r_mem[i].age - 4'd1;
      end
    end
    if (i_push) begin
      r_mem[r_tail] <= i_push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (o_pop) begin
        r_head <= ptr_inc(r_head);
      end
      if (i_push && !o_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!i_push && o_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_like_mem_responder.sv
// Memory-side responder for the sram-like interface: word RAM with byte-masked writes and a
// fixed-latency, fully pipelined response path with bounded outstanding requests.
module sram_like_mem_responder
  import sram_like_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_stall,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  logic [31:0]           r_ram [2**ADDR_WIDTH];
  logic                  r_data_ok;
  logic [31:0]           r_rdata;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_bitmask;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_count;
  logic                  w_pop;
  logic                  w_head_is_read;
  logic [31:0]           w_head_data;
  resp_entry_t           w_push_entry;
  logic                  w_unused_addr;

  assign w_idx         = i_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^i_addr[31:ADDR_WIDTH+2];
  assign w_bitmask     = mask_expand(wr_mask(i_size, i_addr[1:0]));

  // No bypass: a full queue refuses even when the head pops this cycle.
  assign o_addr_ok = ~rst & i_req & ~i_stall & (w_count < CNT_W'(OUTSTANDING));
  assign w_accept  = i_req & o_addr_ok;

  assign w_push_entry = '{is_read: ~i_wr, data: r_ram[w_idx], age: 4'(LATENCY - 1)};

  always_ff @(posedge clk) begin
    if (w_accept && i_wr) begin
      r_ram[w_idx] <= (r_ram[w_idx] & ~w_bitmask) | (i_wdata & w_bitmask);
    end
  end

  sram_like_resp_queue #(
    .DEPTH (OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_resp_queue (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_accept),
    .i_push_entry   (w_push_entry),
    .o_pop          (w_pop),
    .o_head_is_read (w_head_is_read),
    .o_head_data    (w_head_data),
    .o_count        (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= w_pop;
      r_rdata   <= (w_pop && w_head_is_read) ? w_head_data : '0;
    end
  end

  assign o_data_ok = r_data_ok;
  assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Scoreboard bench for sram_like_mem_responder: a driver predicts responses from a word-array
// model and queues them with their due cycle; a monitor checks every cycle of the response port.
module tb_sram_like_mem_responder;

  localparam int unsigned AW   = 12;
  localparam int unsigned LAT  = 5;
  localparam int unsigned OUTS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b1;
  logic        i_wr = 1'b0;
  logic [1:0]  i_size = 2'b10;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_stall = 1'b0;
  logic        o_addr_ok;
  logic        o_data_ok;
  logic [31:0] o_rdata;

  sram_like_mem_responder #(
    .ADDR_WIDTH  (AW),
    .LATENCY     (LAT),
    .OUTSTANDING (OUTS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_wr      (i_wr),
    .i_size    (i_size),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_stall   (i_stall),
    .o_addr_ok (o_addr_ok),
    .o_data_ok (o_data_ok),
    .o_rdata   (o_rdata)
  );

  always #5 clk = ~clk;

  // cyc == k while in the cycle following rising edge k.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [int unsigned];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int pending();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].due > cyc) n++;
    return n;
  endfunction

  // Plain lane replacement: a size-byte access covers the naturally aligned group holding addr.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] lo);
    int nb;
    int first;
    logic [31:0] res = old;
    nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    first = (int'(lo) / nb) * nb;
    for (int b = first; b < first + nb; b++) res[b*8 +: 8] = wd[b*8 +: 8];
    return res;
  endfunction

  task automatic drive(input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic stall,
                       output logic acc);
    int unsigned idx;
    logic [31:0] old;
    exp_t e;
    @(negedge clk);
    i_req = req; i_wr = wr; i_size = size; i_addr = addr; i_wdata = wdata; i_stall = stall;
    #1;
    acc = req && !stall && (pending() < OUTS);
    check("addr_ok", {31'b0, o_addr_ok}, {31'b0, acc});
    if (acc) begin
      idx = (addr >> 2) % (1 << AW);
      old = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      e.due = cyc + LAT + 1;
      if (wr) begin
        mem_m[idx] = merge(old, wdata, size, addr[1:0]);
        e.rdata = 32'h0;
      end else begin
        e.rdata = old;
      end
      exp_q.push_back(e);
    end
  endtask

  // Keep one request presented until it is taken.
  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) drive(1'b1, wr, size, addr, wdata, 1'b0, acc);
    if (!acc) begin
      total++; bad++;
      $display("FAIL issue_timeout: got no acceptance expected acceptance for addr %h", addr);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) idle(1);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d responses left expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_req = 1'b1; i_stall = 1'b0;
    #1;
    check("addr_ok_in_reset", {31'b0, o_addr_ok}, 32'h0);
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          check("data_ok", {31'b0, o_data_ok}, 32'h1);
          check("rdata", o_rdata, e.rdata);
        end else begin
          check("data_ok_idle", {31'b0, o_data_ok}, 32'h0);
          check("rdata_idle", o_rdata, 32'h0);
        end
      end
    end
  end

  initial begin : stim
    logic acc;
    int   n_acc;
    @(negedge clk);
    #1;
    check("addr_ok_in_reset", {31'b0, o_addr_ok}, 32'h0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0;

    for (int i = 0; i < 16; i++) issue(1'b1, 2'b10, i * 4, $urandom);
    drain();

    issue(1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 32'h0000_0010, 32'h0);
    issue(1'b1, 2'b10, 32'h0000_0000, 32'h1122_3344);
    issue(1'b1, 2'b00, 32'h0000_0002, 32'h00AA_0000);
    issue(1'b1, 2'b01, 32'h0000_0000, 32'h0000_BEEF);
    issue(1'b0, 2'b10, 32'h0000_0000, 32'h0);
    drain();
    check("masked_word_model", mem_m[0], 32'h11AA_BEEF);

    // Six back-to-back reads: queue fills, then refuses until the first response pops.
    n_acc = 0;
    for (int k = 0; k < 30 && n_acc < 6; k++) begin
      drive(1'b1, 1'b0, 2'b10, 32'(n_acc * 4), 32'h0, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("six_reads_accepted", n_acc, 6);
    drain();

    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 2'b10, 32'h4000, 32'h5, 1'b1, acc);
    issue(1'b1, 2'b10, 32'h0000_4000, 32'h0000_0005);
    issue(1'b0, 2'b10, 32'h0000_0000, 32'h0);
    drain();
    check("wrap_word_model", mem_m[0], 32'h5);

    // Reset lands one edge before the first response is due.
    issue(1'b1, 2'b10, 32'h0000_0008, 32'h0000_0077);
    issue(1'b0, 2'b10, 32'h0000_0004, 32'h0);
    issue(1'b0, 2'b10, 32'h0000_000C, 32'h0);
    idle(LAT - 4);
    do_reset();
    idle(LAT + 2);
    for (int k = 0; k < OUTS; k++) begin
      drive(1'b1, 1'b0, 2'b10, 32'h0000_0008, 32'h0, 1'b0, acc);
    end
    drain();

    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
              ($urandom << 14) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
              $urandom, $urandom_range(0, 4) == 0, acc);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
